// File: rtl/johnson_decoder_if.sv
// Bus bundle between a Johnson code source and the johnson_decoder integrity monitor.
// The master side drives the code and the error clear; the slave side is the decoder.
interface johnson_decoder_if #(
  parameter int WIDTH = 4
);
  localparam int N  = 2 * WIDTH;
  localparam int IW = $clog2(N);

  logic [WIDTH-1:0] q;
  logic             clr_err;
  logic [IW-1:0]    index;
  logic [N-1:0]     onehot;
  logic             valid;
  logic             code_err;
  logic             seq_err;
  logic             locked;
  logic [7:0]       err_count;

  modport master (
    output q, clr_err,
    input  index, onehot, valid, code_err, seq_err, locked, err_count
  );

  modport slave (
    input  q, clr_err,
    output index, onehot, valid, code_err, seq_err, locked, err_count
  );
endinterface

// File: rtl/johnson_decoder.sv
// Decodes a Johnson code bus into index/one-hot form, flags illegal codes and steps,
// tracks lock to a correctly stepping counter and keeps a saturating error count.
module johnson_decoder #(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 4,
  parameter int ALLOW_HOLD = 0
) (
  input  logic            clk,
  input  logic            reset,
  johnson_decoder_if.slave bus
);
  localparam int N  = 2 * WIDTH;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  state_t        state_q, state_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic [IW-1:0] index_q, index_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic          valid_q, valid_d;
  logic          codeErr_q, codeErr_d;
  logic          seqErr_q, seqErr_d;
  logic [7:0]    errCount_q, errCount_d;

  logic [WIDTH-1:0] packedOnes;
  logic [IW-1:0]    ones;
  logic [IW-1:0]    curIdx;
  logic [IW-1:0]    succIdx;
  logic             legal;
  logic             isStep;

  // Codes with the MSB set are inverted so both halves become "ones packed from bit 0".
  always_comb begin
    packedOnes = bus.q[WIDTH-1] ? ~bus.q : bus.q;
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + IW'(packedOnes[i]);
    end
    legal  = ((packedOnes & (packedOnes + WIDTH'(1))) == '0);
    curIdx = bus.q[WIDTH-1] ? (IW'(WIDTH) + ones) : ones;
  end

  always_comb begin
    succIdx  = (index_q == IW'(N - 1)) ? '0 : (index_q + IW'(1));
    isStep   = (curIdx == succIdx) || ((ALLOW_HOLD != 0) && (curIdx == index_q));
    seqErr_d = legal && valid_q && !isStep;
    valid_d  = legal;
    codeErr_d = !legal;
    index_d  = legal ? curIdx : index_q;
    onehot_d = legal ? ({{(N-1){1'b0}}, 1'b1} << curIdx) : '0;
  end

  // Counting the previously registered error keeps err_count one edge behind the flags.
  always_comb begin
    errCount_d = errCount_q;
    if (bus.clr_err) begin
      errCount_d = '0;
    end else if ((codeErr_q || seqErr_q) && (errCount_q != 8'hFF)) begin
      errCount_d = errCount_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      HUNT: begin
        if (legal) begin
          state_d = SYNC;
          gcnt_d  = '0;
        end
      end
      SYNC: begin
        if (!legal) begin
          state_d = HUNT;
          gcnt_d  = '0;
        end else if (seqErr_d) begin
          gcnt_d = '0;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
          if ((gcnt_q + 4'd1) == 4'(LOCK_CNT)) begin
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        if (!legal || seqErr_d) begin
          state_d = HUNT;
          gcnt_d  = '0;
        end
      end
      default: begin
        state_d = HUNT;
        gcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      gcnt_q     <= '0;
      index_q    <= '0;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      codeErr_q  <= 1'b0;
      seqErr_q   <= 1'b0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      gcnt_q     <= gcnt_d;
      index_q    <= index_d;
      onehot_q   <= onehot_d;
      valid_q    <= valid_d;
      codeErr_q  <= codeErr_d;
      seqErr_q   <= seqErr_d;
      errCount_q <= errCount_d;
    end
  end

  assign bus.index     = index_q;
  assign bus.onehot    = onehot_q;
  assign bus.valid     = valid_q;
  assign bus.code_err  = codeErr_q;
  assign bus.seq_err   = seqErr_q;
  assign bus.locked    = (state_q == LOCK);
  assign bus.err_count = errCount_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench: two decoders (hold disallowed / allowed) fed the same code stream,
// compared every cycle against a table-driven reference model.
module tb_johnson_decoder;
  localparam int W  = 4;
  localparam int N  = 2 * W;
  localparam int LC = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  johnson_decoder_if #(.WIDTH(W)) bus0 ();
  johnson_decoder_if #(.WIDTH(W)) bus1 ();

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LC), .ALLOW_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LC), .ALLOW_HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int codeTab [N];
  int mIdx [2], mOnehot [2], mValid [2], mCodeErr [2], mSeqErr [2];
  int mMode [2], mGood [2], mErr [2];
  int cur;

  // Legal codes come from replaying the counter itself: shift left, feed back inverted MSB.
  task automatic buildTable();
    int c = 0;
    for (int k = 0; k < N; k++) begin
      codeTab[k] = c;
      c = ((c << 1) | ((~(c >> (W - 1))) & 1)) & ((1 << W) - 1);
    end
  endtask

  function automatic int lookup(input logic [W-1:0] c);
    for (int k = 0; k < N; k++) begin
      if (codeTab[k] == int'(c)) return k;
    end
    return -1;
  endfunction

  task automatic resetModel();
    for (int h = 0; h < 2; h++) begin
      mIdx[h] = 0; mOnehot[h] = 0; mValid[h] = 0; mCodeErr[h] = 0;
      mSeqErr[h] = 0; mMode[h] = 0; mGood[h] = 0; mErr[h] = 0;
    end
  endtask

  // Mode 0 = hunting, 1 = counting good steps, 2 = locked.
  task automatic modelStep(input logic [W-1:0] code, input logic clr);
    int k;
    bit legal, seq, prevErr;
    k = lookup(code);
    legal = (k >= 0);
    for (int h = 0; h < 2; h++) begin
      prevErr = (mCodeErr[h] != 0) || (mSeqErr[h] != 0);
      if (clr) mErr[h] = 0;
      else if (prevErr && mErr[h] < 255) mErr[h]++;
      seq = legal && (mValid[h] != 0) &&
            !((k == (mIdx[h] + 1) % N) || (h == 1 && k == mIdx[h]));
      case (mMode[h])
        0: if (legal) begin mMode[h] = 1; mGood[h] = 0; end
        1: begin
          if (!legal) mMode[h] = 0;
          else if (seq) mGood[h] = 0;
          else begin
            mGood[h]++;
            if (mGood[h] == LC) mMode[h] = 2;
          end
        end
        default: if (!legal || seq) mMode[h] = 0;
      endcase
      if (legal) mIdx[h] = k;
      mOnehot[h]  = legal ? (1 << k) : 0;
      mValid[h]   = legal ? 1 : 0;
      mCodeErr[h] = legal ? 0 : 1;
      mSeqErr[h]  = seq ? 1 : 0;
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ":index0"},  32'(bus0.index),     32'(mIdx[0]));
    cmp({tag, ":onehot0"}, 32'(bus0.onehot),    32'(mOnehot[0]));
    cmp({tag, ":valid0"},  32'(bus0.valid),     32'(mValid[0]));
    cmp({tag, ":cerr0"},   32'(bus0.code_err),  32'(mCodeErr[0]));
    cmp({tag, ":serr0"},   32'(bus0.seq_err),   32'(mSeqErr[0]));
    cmp({tag, ":lock0"},   32'(bus0.locked),    32'(mMode[0] == 2));
    cmp({tag, ":ecnt0"},   32'(bus0.err_count), 32'(mErr[0]));
    cmp({tag, ":index1"},  32'(bus1.index),     32'(mIdx[1]));
    cmp({tag, ":onehot1"}, 32'(bus1.onehot),    32'(mOnehot[1]));
    cmp({tag, ":valid1"},  32'(bus1.valid),     32'(mValid[1]));
    cmp({tag, ":cerr1"},   32'(bus1.code_err),  32'(mCodeErr[1]));
    cmp({tag, ":serr1"},   32'(bus1.seq_err),   32'(mSeqErr[1]));
    cmp({tag, ":lock1"},   32'(bus1.locked),    32'(mMode[1] == 2));
    cmp({tag, ":ecnt1"},   32'(bus1.err_count), 32'(mErr[1]));
  endtask

  task automatic driveStep(input string tag, input logic [W-1:0] code, input logic clr);
    bus0.q = code; bus1.q = code;
    bus0.clr_err = clr; bus1.clr_err = clr;
    @(posedge clk);
    modelStep(code, clr);
    #1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input string tag, input logic [W-1:0] code, input logic clr);
    @(negedge clk);
    driveStep(tag, code, clr);
  endtask

  task automatic stepIdx(input string tag, input int k);
    applyStimulus(tag, W'(codeTab[k % N]), 1'b0);
  endtask

  initial begin
    buildTable();
    resetModel();
    bus0.q = '0; bus1.q = '0;
    bus0.clr_err = 1'b0; bus1.clr_err = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");

    // Free-running sequence, released straight into the first sample.
    @(negedge clk);
    reset = 1'b0;
    driveStep("run", W'(codeTab[0]), 1'b0);
    for (int i = 1; i < 16; i++) begin
      stepIdx("run", i);
      if (i == 4) cmp("lock_after_5th_edge", 32'(bus0.locked), 32'd1);
    end
    cmp("no_err_through_wrap", 32'(bus0.err_count), 32'd0);

    // Illegal code while locked.
    applyStimulus("illegal", 4'b0101, 1'b0);
    cmp("illegal_onehot", 32'(bus0.onehot), 32'd0);
    cmp("illegal_index_hold", 32'(bus0.index), 32'd7);
    cmp("illegal_unlock", 32'(bus0.locked), 32'd0);
    stepIdx("after_illegal", 3);
    cmp("after_illegal_no_seq", 32'(bus0.seq_err), 32'd0);
    cmp("after_illegal_ecnt", 32'(bus0.err_count), 32'd1);

    // Re-lock then skip 2 -> 4.
    for (int i = 4; i <= 10; i++) stepIdx("relock", i);
    cmp("relock_locked", 32'(bus0.locked), 32'd1);
    stepIdx("skip", 4);
    cmp("skip_seq", 32'(bus0.seq_err), 32'd1);
    cmp("skip_valid", 32'(bus0.valid), 32'd1);
    cmp("skip_index", 32'(bus0.index), 32'd4);
    cmp("skip_unlock", 32'(bus0.locked), 32'd0);
    stepIdx("skip_next", 5);
    cmp("skip_ecnt", 32'(bus0.err_count), 32'd2);

    // Hold on 0111 once locked again.
    for (int i = 6; i <= 11; i++) stepIdx("prehold", i);
    applyStimulus("hold", 4'b0111, 1'b0);
    cmp("hold_seq_nohold", 32'(bus0.seq_err), 32'd1);
    cmp("hold_seq_allow", 32'(bus1.seq_err), 32'd0);
    cmp("hold_lock_allow", 32'(bus1.locked), 32'd1);

    // Saturation then clear.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("sat", 4'b0101, 1'b0);
      applyStimulus("sat", 4'b0000, 1'b0);
    end
    cmp("sat_255", 32'(bus0.err_count), 32'd255);
    applyStimulus("clr", 4'b0101, 1'b1);
    applyStimulus("clr", 4'b0000, 1'b1);
    cmp("clr_zero", 32'(bus0.err_count), 32'd0);
    cmp("clr_zero_allow", 32'(bus1.err_count), 32'd0);
    applyStimulus("clr_off", 4'b0000, 1'b0);

    // Random walk: mostly good steps with holds, skips and garbage mixed in.
    cur = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 14) begin
        cur = (cur + 1) % N;
        stepIdx("rand", cur);
      end else if (r < 16) begin
        stepIdx("rand", cur);
      end else if (r < 18) begin
        cur = int'($urandom_range(0, N - 1));
        stepIdx("rand", cur);
      end else begin
        logic [W-1:0] g;
        g = W'($urandom_range(0, (1 << W) - 1));
        applyStimulus("rand", g, 1'b0);
        if (lookup(g) >= 0) cur = lookup(g);
      end
    end

    // Asynchronous reset while locked.
    for (int i = 1; i <= 8; i++) stepIdx("prereset", cur + i);
    cmp("prereset_locked", 32'(bus0.locked), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    resetModel();
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    checkOutput("reset_held");
    @(negedge clk);
    reset = 1'b0;
    driveStep("restart", W'(codeTab[6]), 1'b0);
    cmp("restart_no_seq", 32'(bus0.seq_err), 32'd0);
    for (int i = 7; i <= 10; i++) stepIdx("restart", i);
    cmp("restart_lock_5", 32'(bus0.locked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
